alu_muldiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit; multi-cycle companion to the

---
 rtl/alu_muldiv_if.sv | 26 ++
 rtl/alu_muldiv_iter.sv | 134 +++++++++++++
 tb/tb_alu_muldiv_iter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid may not drop and its payload may not change until that edge.
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic             out_div0;

  modport master (
    output in_valid, in_op, in_x, in_y, flush, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_div0
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, flush, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_div0
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; works on magnitudes and
// fixes signs at the end. FSM: IDLE -> ITER -> FIX -> DONE -> IDLE.
module alu_muldiv_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus,
  output logic [1:0] state_dbg
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   x_orig;
  logic               is_div, neg_lo, neg_hi, div0;
  logic               accept, sx, sy;
  logic [WIDTH-1:0]   abs_x, abs_y;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // acc = {upper W+1 bits, lower W bits}. MUL: upper accumulates and the
  // multiplier shifts out of the bottom. DIV: upper is the partial remainder,
  // quotient bits shift into the bottom.
  function automatic logic [2*WIDTH:0] step(input logic [2*WIDTH:0] a,
                                            input logic [WIDTH-1:0] d,
                                            input logic             div);
    logic [2*WIDTH:0] r;
    logic [WIDTH:0]   d_ext;
    r     = a;
    d_ext = {1'b0, d};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div) begin
        r = r << 1;
        if (r[2*WIDTH:WIDTH] >= d_ext) begin
          r[2*WIDTH:WIDTH] = r[2*WIDTH:WIDTH] - d_ext;
          r[0]             = 1'b1;
        end
      end else begin
        if (r[0]) r[2*WIDTH:WIDTH] = r[2*WIDTH:WIDTH] + d_ext;
        r = r >> 1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) state_nxt = S_ITER;
        S_ITER: if (cnt == '0)    state_nxt = S_FIX;
        S_FIX:                    state_nxt = S_DONE;
        S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
        default:                  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    state_dbg     = state;
  end

  assign accept = (state == S_IDLE) && bus.in_valid && !bus.flush;
  assign sx     = ~bus.in_op[0] & bus.in_x[WIDTH-1];
  assign sy     = ~bus.in_op[0] & bus.in_y[WIDTH-1];
  assign abs_x  = sx ? -bus.in_x : bus.in_x;
  assign abs_y  = sy ? -bus.in_y : bus.in_y;

  assign prod_fix = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // The ITER cycle that finds cnt==0 performs no step; it keeps latency at N+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      acc          <= '0;
      opnd         <= '0;
      x_orig       <= '0;
      is_div       <= 1'b0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      div0         <= 1'b0;
      bus.out_hi   <= '0;
      bus.out_lo   <= '0;
      bus.out_div0 <= 1'b0;
    end else begin
      if (accept) begin
        is_div <= bus.in_op[1];
        neg_lo <= sx ^ sy;
        neg_hi <= sx;
        div0   <= bus.in_op[1] && (bus.in_y == '0);
        x_orig <= bus.in_x;
        opnd   <= abs_y;
        acc    <= {{(WIDTH+1){1'b0}}, abs_x};
        cnt    <= CW'(N);
      end else if (state == S_ITER && !bus.flush && cnt != '0) begin
        acc <= step(acc, opnd, is_div);
        cnt <= cnt - CW'(1);
      end

      if (state == S_FIX && !bus.flush) begin
        if (!is_div) begin
          {bus.out_hi, bus.out_lo} <= prod_fix;
          bus.out_div0             <= 1'b0;
        end else if (div0) begin
          bus.out_hi   <= x_orig;
          bus.out_lo   <= '1;
          bus.out_div0 <= 1'b1;
        end else begin
          bus.out_hi   <= rem_fix;
          bus.out_lo   <= quo_fix;
          bus.out_div0 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter: BITS_PER_CYCLE=1 and =4 instances share stimulus,
// sel chooses which one sees requests and which one is observed.
module tb_alu_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel = 1'b0;
  logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [1:0]   in_op = 2'd0;
  logic [W-1:0] in_x = '0, in_y = '0;

  alu_muldiv_if #(.WIDTH(W)) b1();
  alu_muldiv_if #(.WIDTH(W)) b4();
  logic [1:0] st1, st4;

  assign b1.in_valid  = in_valid & ~sel;
  assign b1.flush     = flush & ~sel;
  assign b1.in_op     = in_op;
  assign b1.in_x      = in_x;
  assign b1.in_y      = in_y;
  assign b1.out_ready = out_ready;
  assign b4.in_valid  = in_valid & sel;
  assign b4.flush     = flush & sel;
  assign b4.in_op     = in_op;
  assign b4.in_x      = in_x;
  assign b4.in_y      = in_y;
  assign b4.out_ready = out_ready;

  alu_muldiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .state_dbg(st1));
  alu_muldiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .state_dbg(st4));

  logic         o_valid, o_ready, o_div0;
  logic [W-1:0] o_hi, o_lo;
  logic [1:0]   o_state;
  assign o_valid = sel ? b4.out_valid : b1.out_valid;
  assign o_ready = sel ? b4.in_ready  : b1.in_ready;
  assign o_div0  = sel ? b4.out_div0  : b1.out_div0;
  assign o_hi    = sel ? b4.out_hi    : b1.out_hi;
  assign o_lo    = sel ? b4.out_lo    : b1.out_lo;
  assign o_state = sel ? st4 : st1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_hi_q[$];
  logic [W-1:0] exp_lo_q[$];
  logic         exp_d0_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] x, y, hi, lo;
    logic         d0;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model built on native wide arithmetic.
  task automatic model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic d0);
    longint          sp;
    longint unsigned up;
    int              sxv, syv;
    d0 = 1'b0;
    sxv = x;
    syv = y;
    case (op)
      2'd0: begin sp = longint'(sxv) * longint'(syv); {hi, lo} = sp; end
      2'd1: begin up = longint'({32'd0, x}) * longint'({32'd0, y}); {hi, lo} = up; end
      default: begin
        if (y == '0) begin
          lo = '1; hi = x; d0 = 1'b1;
        end else if (op == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = '0;
        end else if (op == 2'd2) begin
          lo = sxv / syv; hi = sxv % syv;
        end else begin
          lo = x / y; hi = x % y;
        end
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input logic d0, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_wait", o_ready, 1);
    in_op = op; in_x = x; in_y = y; in_valid = 1'b1;
    if (push) begin exp_hi_q.push_back(hi); exp_lo_q.push_back(lo); exp_d0_q.push_back(d0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = $urandom; in_y = $urandom; in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(input int lat, input int hold);
    int n;
    bit seen;
    logic [W-1:0] eh, el;
    logic ed;
    n = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (o_valid) seen = 1;
    end
    check("out_valid_timeout", seen, 1);
    if (exp_hi_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ed = exp_d0_q.pop_front();
      if (seen) begin
        check("latency", n, lat);
        check("out_hi", o_hi, eh);
        check("out_lo", o_lo, el);
        check("out_div0", o_div0, ed);
        for (int h = 0; h < hold; h++) begin
          in_valid = 1'b1;
          @(posedge clk); #1;
          check("hold_valid", o_valid, 1);
          check("hold_ready", o_ready, 0);
          check("hold_state", o_state, 3);
          check("hold_data", {o_hi, o_lo}, {eh, el});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", o_valid, 0);
        check("release_ready", o_ready, 1);
        check("keep_data", {o_hi, o_lo}, {eh, el});
      end
    end
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] x, y, hi, lo;
    logic         d0;
    int           lat;
    bit           seen;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

    #12;
    check("rst_valid1", b1.out_valid, 0);
    check("rst_ready1", b1.in_ready, 1);
    check("rst_data1", {b1.out_hi, b1.out_lo, 7'd0, b1.out_div0}, 0);
    check("rst_state1", st1, 0);
    check("rst_valid4", b4.out_valid, 0);
    check("rst_ready4", b4.in_ready, 1);
    check("rst_data4", {b4.out_hi, b4.out_lo, 7'd0, b4.out_div0}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = (s == 0) ? 34 : 10;
      for (int v = 0; v < 10; v++) begin
        issue(vecs[v].op, vecs[v].x, vecs[v].y, vecs[v].hi, vecs[v].lo, vecs[v].d0, 1);
        collect(lat, 0);
      end
      for (int r = 0; r < 8; r++) begin
        op = 2'($urandom_range(0, 3));
        x  = $urandom;
        case ($urandom_range(0, 3))
          0:       y = '0;
          1:       y = W'($urandom_range(1, 100));
          default: y = $urandom;
        endcase
        model(op, x, y, hi, lo, d0);
        issue(op, x, y, hi, lo, d0, 1);
        collect(lat, 0);
      end
    end

    sel = 1'b0;
    issue(2'd1, 32'd9, 32'd5, 32'd0, 32'h2D, 1'b0, 1);
    collect(34, 5);

    issue(2'd1, 32'hFFFF_FFFF, 32'd2, '0, '0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", o_valid, 0);
    check("flush_state", o_state, 0);
    check("flush_data", {o_hi, o_lo}, {32'd0, 32'h2D});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1;
    end
    check("flushed_no_valid", seen, 0);
    issue(2'd1, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0, 1);
    collect(34, 0);

    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 2'd1; in_x = 32'd3; in_y = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_state", o_state, 0);
    check("flush_idle_ready", o_ready, 1);

    issue(2'd3, 32'd100, 32'd7, '0, '0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_data", {o_hi, o_lo}, 0);
    check("arst_div0", o_div0, 0);
    check("arst_state", o_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    collect(34, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
